// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the condition field against the flags and gates the write enables.
// Latency: write enables and CondEx are combinational (0 cycles); Flags and the counters update on the next clk edge.
// Backpressure: none. An instruction is accepted every cycle it is presented, and it is counted or squashed in that same cycle.
module cond_logic (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InstrValid,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        NoWrite,
  input  logic        CntClr,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        CondEx,
  output logic [3:0]  Flags,
  output logic [15:0] ExecCount,
  output logic [15:0] SkipCount
);

  // Condition-field encodings from instruction bits [31:28].
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Architectural state.
  logic [3:0]  flags_q,     flags_d;
  logic [15:0] exec_cnt_q,  exec_cnt_d;
  logic [15:0] skip_cnt_q,  skip_cnt_d;

  // Unpacked view of the registered flags.
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;
  logic exec;
  cond_e cond_sel;

  assign flag_n   = flags_q[3];
  assign flag_z   = flags_q[2];
  assign flag_c   = flags_q[1];
  assign flag_v   = flags_q[0];
  assign cond_sel = cond_e'(Cond);

  // Evaluate the condition from the registered flags only. A flag update made this
  // cycle is therefore seen from the following cycle onward. The reset value of the
  // flags is 0000, so EQ fails and NE passes while reset is held.
  always_comb begin
    cond_pass = 1'b0;
    unique case (cond_sel)
      COND_EQ: cond_pass = flag_z;
      COND_NE: cond_pass = ~flag_z;
      COND_CS: cond_pass = flag_c;
      COND_CC: cond_pass = ~flag_c;
      COND_MI: cond_pass = flag_n;
      COND_PL: cond_pass = ~flag_n;
      COND_VS: cond_pass = flag_v;
      COND_VC: cond_pass = ~flag_v;
      COND_HI: cond_pass = flag_c & ~flag_z;
      COND_LS: cond_pass = ~flag_c | flag_z;
      COND_GE: cond_pass = (flag_n == flag_v);
      COND_LT: cond_pass = (flag_n != flag_v);
      COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_pass = flag_z | (flag_n != flag_v);
      COND_AL: cond_pass = 1'b1;
      COND_NV: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  // Gate the write enables with the condition. A compare instruction sets NoWrite,
  // which suppresses only the register write. Its flag update still goes ahead.
  always_comb begin
    exec     = InstrValid & cond_pass;
    CondEx   = cond_pass;
    PCSrc    = PCS  & exec;
    MemWrite = MemW & exec;
    RegWrite = RegW & exec & ~NoWrite;
  end

  // Flag next-state: each half loads independently when the instruction executes.
  // A squashed or invalid instruction never touches the flags.
  always_comb begin
    flags_d = flags_q;
    if (exec) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Counter next-state: a clear takes priority and discards the current instruction.
  // Otherwise the instruction is counted as executed or as skipped. Both counters
  // saturate at all-ones instead of wrapping.
  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (CntClr) begin
      exec_cnt_d = '0;
      skip_cnt_d = '0;
    end else if (exec) begin
      if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + 16'd1;
    end else if (InstrValid) begin
      if (skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous clear. The first edge after reset is a normal edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 4'b0000;
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      flags_q    <= flags_d;
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign Flags     = flags_q;
  assign ExecCount = exec_cnt_q;
  assign SkipCount = skip_cnt_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed testbench for cond_logic.
// Inputs are driven after the falling edge. Combinational outputs are sampled 1ns later.
// Registered outputs are sampled 1ns after the rising edge.
module tb_cond_logic;

  logic        clk;
  logic        rst_n;
  logic        InstrValid;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS, RegW, MemW, NoWrite, CntClr;
  logic        PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]  Flags;
  logic [15:0] ExecCount, SkipCount;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_exec;
  logic [15:0] exp_skip;

  cond_logic dut (
    .clk(clk), .rst_n(rst_n), .InstrValid(InstrValid), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .CntClr(CntClr), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
    .ExecCount(ExecCount), .SkipCount(SkipCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference condition evaluation, written out from the condition table.
  function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    InstrValid = 0; Cond = 4'hE; ALUFlags = 0; FlagW = 0;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; CntClr = 0;
  endtask

  // Executes one AL instruction that loads all four flags with f.
  task automatic load_flags(input logic [3:0] f);
    @(negedge clk);
    idle_inputs();
    InstrValid = 1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
    @(posedge clk); #1;
    exp_exec = exp_exec + 16'd1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", Flags); end
    checks++; if (ExecCount !== 16'd0) begin errors++; $display("FAIL reset_exec: got %h expected 0000", ExecCount); end
    checks++; if (SkipCount !== 16'd0) begin errors++; $display("FAIL reset_skip: got %h expected 0000", SkipCount); end
    InstrValid = 1; PCS = 1; Cond = 4'h0; #1;
    checks++; if (PCSrc !== 1'b0 || CondEx !== 1'b0) begin errors++; $display("FAIL reset_eq: got PCSrc=%b CondEx=%b expected 0,0", PCSrc, CondEx); end
    Cond = 4'h1; #1;
    checks++; if (PCSrc !== 1'b1 || CondEx !== 1'b1) begin errors++; $display("FAIL reset_ne: got PCSrc=%b CondEx=%b expected 1,1", PCSrc, CondEx); end
    @(posedge clk); #1;
    checks++; if (ExecCount !== 16'd0 || Flags !== 4'b0000) begin errors++; $display("FAIL reset_hold: got exec=%h flags=%b expected 0,0000", ExecCount, Flags); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    exp_exec = 0; exp_skip = 0;
  endtask

  task automatic test_compare_nowrite();
    @(negedge clk);
    idle_inputs();
    InstrValid = 1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1; NoWrite = 1;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL cmp_regwrite: got %b expected 0", RegWrite); end
    checks++; if (CondEx !== 1'b1) begin errors++; $display("FAIL cmp_condex: got %b expected 1", CondEx); end
    @(posedge clk); #1;
    exp_exec = exp_exec + 16'd1;
    checks++; if (Flags !== 4'b0100) begin errors++; $display("FAIL cmp_flags: got %b expected 0100", Flags); end
    checks++; if (ExecCount !== 16'd1) begin errors++; $display("FAIL cmp_exec: got %h expected 0001", ExecCount); end
  endtask

  task automatic test_branch_eq_ne();
    @(negedge clk);
    idle_inputs();
    InstrValid = 1; Cond = 4'h0; PCS = 1; #1;
    checks++; if (PCSrc !== 1'b1) begin errors++; $display("FAIL br_eq: got %b expected 1", PCSrc); end
    @(posedge clk); #1;
    exp_exec = exp_exec + 16'd1;
    @(negedge clk);
    Cond = 4'h1; #1;
    checks++; if (PCSrc !== 1'b0) begin errors++; $display("FAIL br_ne: got %b expected 0", PCSrc); end
    @(posedge clk); #1;
    exp_skip = exp_skip + 16'd1;
    checks++; if (SkipCount !== 16'd1) begin errors++; $display("FAIL br_skip: got %h expected 0001", SkipCount); end
    checks++; if (ExecCount !== exp_exec) begin errors++; $display("FAIL br_exec: got %h expected %h", ExecCount, exp_exec); end
  endtask

  task automatic test_partial_flags();
    load_flags(4'b0000);
    @(negedge clk);
    idle_inputs();
    InstrValid = 1; Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b1011;
    @(posedge clk); #1;
    exp_exec = exp_exec + 16'd1;
    checks++; if (Flags !== 4'b1000) begin errors++; $display("FAIL partial_flags: got %b expected 1000", Flags); end
  endtask

  task automatic test_lt_memwrite();
    @(negedge clk);
    idle_inputs();
    InstrValid = 1; Cond = 4'hB; MemW = 1; FlagW = 2'b11; ALUFlags = 4'b0000; #1;
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL lt_memwrite: got %b expected 1", MemWrite); end
    @(posedge clk); #1;
    exp_exec = exp_exec + 16'd1;
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL lt_flags: got %b expected 0000", Flags); end
    @(negedge clk);
    ALUFlags = 4'b1111; #1;
    checks++; if (CondEx !== 1'b0 || MemWrite !== 1'b0) begin errors++; $display("FAIL lt_second: got CondEx=%b MemWrite=%b expected 0,0", CondEx, MemWrite); end
    @(posedge clk); #1;
    exp_skip = exp_skip + 16'd1;
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL squash_flags: got %b expected 0000", Flags); end
    checks++; if (SkipCount !== exp_skip) begin errors++; $display("FAIL squash_skip: got %h expected %h", SkipCount, exp_skip); end
  endtask

  task automatic test_same_cycle();
    // The flags are 0000 here. EQ must use the registered Z=0 and ignore ALUFlags Z=1.
    @(negedge clk);
    idle_inputs();
    InstrValid = 1; Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1; #1;
    checks++; if (CondEx !== 1'b0 || RegWrite !== 1'b0) begin errors++; $display("FAIL same_cycle: got CondEx=%b RegWrite=%b expected 0,0", CondEx, RegWrite); end
    @(posedge clk); #1;
    exp_skip = exp_skip + 16'd1;
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL same_cycle_flags: got %b expected 0000", Flags); end
  endtask

  task automatic test_idle();
    @(negedge clk);
    idle_inputs();
    Cond = 4'hE; PCS = 1; RegW = 1; MemW = 1; FlagW = 2'b11; ALUFlags = 4'b1111; #1;
    checks++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin errors++; $display("FAIL idle_we: got %b expected 000", {PCSrc, RegWrite, MemWrite}); end
    @(posedge clk); #1;
    checks++; if (Flags !== 4'b0000 || ExecCount !== exp_exec || SkipCount !== exp_skip) begin
      errors++; $display("FAIL idle_hold: got flags=%b exec=%h skip=%h expected 0000,%h,%h", Flags, ExecCount, SkipCount, exp_exec, exp_skip);
    end
  endtask

  task automatic test_cond_table();
    logic [3:0] pats [6];
    pats = '{4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b0110, 4'b1111};
    for (int p = 0; p < 6; p++) begin
      load_flags(pats[p]);
      @(negedge clk);
      idle_inputs();
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c); #1;
        checks++; if (CondEx !== exp_cond(4'(c), pats[p])) begin
          errors++; $display("FAIL cond_table flags=%b cond=%h: got %b expected %b", pats[p], c[3:0], CondEx, exp_cond(4'(c), pats[p]));
        end
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    idle_inputs();
    CntClr = 1;
    @(posedge clk); #1;
    checks++; if (ExecCount !== 16'd0 || SkipCount !== 16'd0) begin errors++; $display("FAIL clr_idle: got exec=%h skip=%h expected 0,0", ExecCount, SkipCount); end
    @(negedge clk);
    idle_inputs();
    InstrValid = 1; Cond = 4'hE;
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (ExecCount !== 16'hFFFE) begin errors++; $display("FAIL preload: got %h expected FFFE", ExecCount); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ExecCount !== 16'hFFFF) begin errors++; $display("FAIL saturate: got %h expected FFFF", ExecCount); end
    @(negedge clk);
    CntClr = 1;
    @(posedge clk); #1;
    checks++; if (ExecCount !== 16'd0 || SkipCount !== 16'd0) begin errors++; $display("FAIL clr_valid: got exec=%h skip=%h expected 0,0", ExecCount, SkipCount); end
    @(negedge clk);
    idle_inputs();
    exp_exec = 0; exp_skip = 0;
  endtask

  task automatic test_async_reset();
    load_flags(4'b1111);
    @(negedge clk);
    idle_inputs();
    InstrValid = 1; Cond = 4'hF;
    @(posedge clk); #1;
    exp_skip = exp_skip + 16'd1;
    checks++; if (Flags !== 4'b1111 || ExecCount !== exp_exec || SkipCount !== exp_skip) begin
      errors++; $display("FAIL pre_reset: got flags=%b exec=%h skip=%h expected 1111,%h,%h", Flags, ExecCount, SkipCount, exp_exec, exp_skip);
    end
    #2;
    rst_n = 0;
    #1;
    checks++; if (Flags !== 4'b0000 || ExecCount !== 16'd0 || SkipCount !== 16'd0) begin
      errors++; $display("FAIL async_reset: got flags=%b exec=%h skip=%h expected 0000,0,0", Flags, ExecCount, SkipCount);
    end
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    InstrValid = 1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0010;
    @(posedge clk); #1;
    checks++; if (Flags !== 4'b0010 || ExecCount !== 16'd1) begin
      errors++; $display("FAIL first_edge: got flags=%b exec=%h expected 0010,0001", Flags, ExecCount);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    exp_exec = 0; exp_skip = 0;
    test_reset();
    test_compare_nowrite();
    test_branch_eq_ne();
    test_partial_flags();
    test_lt_memwrite();
    test_same_cycle();
    test_idle();
    test_cond_table();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL have a single clock `clk` and a reset `rst_n` that is asynchronous and active-low; `clk`  in  1  rising-edge clock.
REQ-002 `rst_n`  in  1  asynchronous active-low reset.
REQ-003 `InstrValid`  in  1  current instruction is valid this cycle.
REQ-004 `Cond`  in  4  instruction condition field [31:28].
REQ-005 `ALUFlags`  in  4  ALU result flags {N,Z,C,V}, bit 3 = N.
REQ-006 `FlagW`  in  2  flag-write request from the ALU decoder: [1] updates N,Z; [0] updates C,V.
REQ-007 `PCS`, `RegW`, `MemW`, `NoWrite`  in  1 each  unconditioned PC-write, register-write, memory-write and compare-suppress requests.
REQ-008 `CntClr`  in  1  synchronous clear of both counters.
REQ-009 `PCSrc`, `RegWrite`, `MemWrite`  out  1 each  condition-gated write enables.
REQ-010 `CondEx`  out  1  condition passed.
REQ-011 `Flags`  out  4  architectural flag register {N,Z,C,V}.
REQ-012 `ExecCount`, `SkipCount`  out  16 each  count of executed and of squashed valid instructions.

Function
REQ-013 `CondEx` SHALL be combinational from `Cond` and the registered `Flags` (not from `ALUFlags`): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
REQ-014 Let `Exec` = `InstrValid` & `CondEx`; `PCSrc` = `PCS` & `Exec`; `MemWrite` = `MemW` & `Exec`; `RegWrite` = `RegW` & `Exec` & ~`NoWrite`; all three SHALL be combinational, with zero-cycle latency.
REQ-015 On a rising edge with `Exec`=1, `Flags[3:2]` SHALL load `ALUFlags[3:2]` if `FlagW[1]`, and `Flags[1:0]` SHALL load `ALUFlags[1:0]` if `FlagW[0]`; otherwise each half SHALL hold.
REQ-016 Updated flags SHALL be visible on `Flags` and used by `CondEx` from the cycle after the update, never within the same cycle.
REQ-017 A squashed instruction (`InstrValid`=1, `CondEx`=0) SHALL NOT modify `Flags` regardless of `FlagW`.
REQ-018 `NoWrite` SHALL suppress only `RegWrite`; flag update for compares SHALL proceed per REQ-015.
REQ-019 On each rising edge: if `CntClr`=1, both counters SHALL become 0 and ignore the current instruction; else if `Exec`=1, `ExecCount` SHALL increment; else if `InstrValid`=1, `SkipCount` SHALL increment.
REQ-020 Counters SHALL saturate at 16'hFFFF (no wrap) and hold there until cleared.
REQ-021 With `InstrValid`=0, `Flags` and both counters SHALL hold, and all write enables SHALL be 0.

Reset
REQ-022 While `rst_n`=0, `Flags` SHALL be 4'b0000 and `ExecCount`=`SkipCount`=0, asynchronously, including when reset is asserted mid-cycle.
REQ-023 During reset, the outputs in REQ-014 SHALL follow REQ-013 and REQ-014 evaluated against `Flags`=0000, so EQ fails and NE passes.
REQ-024 The first edge after `rst_n` deasserts SHALL behave as a normal functional edge.

Verification
REQ-025 After reset, apply Cond=1110, FlagW=11, ALUFlags=0100, RegW=1, NoWrite=1 -> RegWrite=0, CondEx=1; next cycle Flags=0100, ExecCount=1.
REQ-026 With Flags=0100, apply Cond=0000, PCS=1, then Cond=0001, PCS=1 -> PCSrc=1 then PCSrc=0; SkipCount=1, ExecCount +1.
REQ-027 With Flags=0000, apply Cond=1110, FlagW=10, ALUFlags=1011 -> Flags=1000 (C,V held at 0).
REQ-028 With Flags=1000, apply Cond=1011 (LT) with MemW=1, FlagW=11, ALUFlags=0000, followed by Cond=1011 -> first cycle MemWrite=1; second cycle Flags=0000 and CondEx=0.
REQ-029 With ExecCount preloaded to 16'hFFFE, run 3 AL instructions -> ExecCount=FFFF and holds; CntClr=1 with a concurrent valid instruction -> both counters 0.
REQ-030 Assert rst_n=0 asynchronously mid-cycle with Flags=1111 and counters nonzero -> Flags=0000 and counters=0 before the next clk edge.
